irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller for the 16-bit pipelined CPU.
- Synchronises NSRC asynchronous device lines (KEY, SW-change, timer, spare) and latches rising edges as pending bits.
- Masks them through memory-mapped registers and arbitrates to a single request/ID for the CPU's interrupt-take logic (SII, SIH jump, RETI).
- Sits beside the data-memory I/O decode on the dmemaddr/dmemin/wrmem_M path.

Parameters:
- DBITS, 16, data/address width of the MMIO bus
- NSRC, 4, number of interrupt sources (1..8)
- MASK_ADDR, 16'hFFF4, address of the enable-mask register (R/W)
- PEND_ADDR, 16'hFFF6, address of the pending register (read; write-1-to-clear)

Ports:
- clk  in  1  system clock (PLL c0)
- rst_n  in  1  asynchronous active-low reset
- src  in  NSRC  raw active-high interrupt lines, asynchronous to clk
- addr  in  DBITS  MMIO address (dmemaddr)
- wdata  in  DBITS  MMIO write data (dmemin)
- we  in  1  MMIO write strobe (wrmem_M)
- rdata  out  DBITS  read data; valid when hit=1
- hit  out  1  addr equals MASK_ADDR or PEND_ADDR
- ie  in  1  SCS.IE global enable from CPU
- irq_req  out  1  interrupt request to CPU
- irq_id  out  3  source number to load into SII
- irq_ack  in  1  one-cycle pulse: CPU has taken the interrupt
- irq_done  in  1  one-cycle pulse: CPU retired RETI

Behaviour:
- Reset values: sync flops, edge history, mask, pend, state=IDLE, irq_req, irq_id all 0. rdata/hit are combinational and read 0 with 0 regs.
- Sync: 2-flop synchroniser per source plus a history flop. edge[i] = sync2[i] & ~hist[i].
- Pending: pend[i] is set by edge[i] and cleared by ack of that source or by a write of 1 to bit i at PEND_ADDR.
  - Set wins over any simultaneous clear.
  - Repeated edges while pending do not count.
- Mask: mask[NSRC-1:0] loads wdata[NSRC-1:0] on a write to MASK_ADDR. Upper bits are ignored on write and read as 0.
- Reads are combinational, zero-extended to DBITS: MASK_ADDR returns mask; PEND_ADDR returns pend (raw, unmasked).
- eligible = pend & mask, gated by ie. Fixed priority: lowest index wins.
- FSM:
  - IDLE: if eligible≠0, latch irq_id = winner and go to REQ. irq_ack and irq_done are ignored.
  - REQ: irq_req=1, irq_id held stable.
    - On irq_ack: clear pend[irq_id], go to SERVICE.
    - Else, if ie=0 or pend[irq_id]&mask[irq_id]=0 (masked or cleared by software): go to IDLE. irq_req drops the next cycle.
  - SERVICE: irq_req=0, no nesting. On irq_done, go to IDLE; the next arbitration happens in that IDLE cycle. irq_ack is ignored.
- irq_req is registered, equal to (state==REQ).
- Latency: a src rise meeting setup before edge 0 sets pend at edge 2, enters REQ at edge 3, and irq_req is visible after edge 3.
- Minimum re-request gap after irq_done: 1 cycle.
- A source held high through reset produces exactly one edge after rst_n deasserts.
- Asynchronous reset mid-REQ/SERVICE returns to IDLE immediately with irq_req=0. The CPU must also clear its own state.
- NSRC<8: irq_id upper bits are 0.

Optional Feature:
- IRQ_ROTATE_PRI_EN
  - Defined: round-robin arbitration. A last-granted pointer (reset 0) is updated on irq_ack. Search starts at (last+1) mod NSRC.
  - Undefined: fixed lowest-index priority; no pointer register exists.

Decomposition:
- Shared package irq_pkg holds:
  - MASK_ADDR/PEND_ADDR defaults, alongside the existing I/O addresses FFF0/FFF2/FFF8/FFFA/FFFC.
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Source numbering constants: SRC_KEY=0, SRC_SW=1, SRC_TMR=2, SRC_SPARE=3.
- One sub-module, irq_arb: combinational priority/round-robin picker, taking eligible and last and returning valid and id.

Test Plan:
1. Reset, mask=4'b0011 written at FFF4, ie=1, pulse src[1] → pend reads 0x0002 at FFF6; irq_req=1 with irq_id=1 three edges after the pulse. irq_ack → pend=0, irq_req=0. irq_done → IDLE.
2. Simultaneous src[3] and src[0] rises with mask=0xF → irq_id=0 first. After ack/done, irq_id=3. With IRQ_ROTATE_PRI_EN and last=0, src[0] and src[1] both pending → irq_id=1.
3. In REQ for id 2, write mask=0 → irq_req deasserts next cycle. Rewrite mask=0x4 → irq_req reasserts with id 2 (pend still 1).
4. pend[1]=1, write 0x0002 to FFF6 in the same cycle a new src[1] edge arrives → pend[1] stays 1. A later W1C alone → reads 0.
5. ie=0 with pend=0x1, mask=0x1 → irq_req stays 0. Raise ie → irq_req=1, id 0. irq_ack in IDLE or SERVICE has no effect.
6. Assert rst_n=0 during SERVICE → irq_req=0, mask=0, pend=0 at once. src[2] held high through reset → exactly one pend[2] set after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: MMIO map, FSM encoding, source numbering.
package irq_pkg;

  // Existing device registers on the I/O page, kept here so the whole map is visible in one place.
  localparam logic [15:0] IO_ADDR_FFF0 = 16'hFFF0;
  localparam logic [15:0] IO_ADDR_FFF2 = 16'hFFF2;
  localparam logic [15:0] IO_ADDR_FFF8 = 16'hFFF8;
  localparam logic [15:0] IO_ADDR_FFFA = 16'hFFFA;
  localparam logic [15:0] IO_ADDR_FFFC = 16'hFFFC;

  // Interrupt controller registers.
  localparam logic [15:0] MASK_ADDR_DEF = 16'hFFF4;
  localparam logic [15:0] PEND_ADDR_DEF = 16'hFFF6;

  // Source numbering on the src bus.
  localparam int unsigned SRC_KEY   = 0;
  localparam int unsigned SRC_SW    = 1;
  localparam int unsigned SRC_TMR   = 2;
  localparam int unsigned SRC_SPARE = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_arb.sv
// Combinational interrupt picker. Fixed lowest-index priority by default; round-robin starting
// after the last granted source when IRQ_ROTATE_PRI_EN is defined.
module irq_arb #(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0] eligible_i,
  input  logic [2:0]      last_i,
  output logic            valid_o,
  output logic [2:0]      id_o
);

`ifdef IRQ_ROTATE_PRI_EN
  // Walk the sources starting at (last + 1) mod NSRC; first eligible one wins.
  always_comb begin
    int unsigned idx;
    valid_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = (32'(last_i) + 32'd1 + k) % NSRC;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (!valid_o && (i == idx) && eligible_i[i]) begin
          valid_o = 1'b1;
          id_o    = 3'(i);
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  // Scan from the top down so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        valid_o = 1'b1;
        id_o    = 3'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw device lines, latches rising edges as pending bits,
// masks them through two MMIO registers and hands one request/ID to the CPU.
// Optional round-robin arbitration is enabled with the IRQ_ROTATE_PRI_EN macro.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned      DBITS     = 16,
  parameter int unsigned      NSRC      = 4,
  parameter logic [DBITS-1:0] MASK_ADDR = DBITS'(MASK_ADDR_DEF),
  parameter logic [DBITS-1:0] PEND_ADDR = DBITS'(PEND_ADDR_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  src,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  input  logic             ie,
  output logic             irq_req,
  output logic [2:0]       irq_id,
  input  logic             irq_ack,
  input  logic             irq_done
);

  logic [NSRC-1:0] sync1_q, sync2_q, hist_q;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] id_onehot;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic            mask_hit, pend_hit;
  logic            cur_live;
  logic            take_ack;
  logic            arb_valid;
  logic [2:0]      arb_id;
  logic [2:0]      last;
  logic [2:0]      irq_id_q, irq_id_d;
  irq_state_e      state_q, state_d;

  logic unused_wdata;
  assign unused_wdata = ^wdata[DBITS-1:NSRC];

  assign mask_hit = (addr == MASK_ADDR);
  assign pend_hit = (addr == PEND_ADDR);
  assign hit      = mask_hit | pend_hit;

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~hist_q;

  // Mask load, W1C decode and pending update; a new edge beats any clear in the same cycle.
  always_comb begin
    mask_d = mask_q;
    w1c    = '0;
    if (we && mask_hit) mask_d = wdata[NSRC-1:0];
    if (we && pend_hit) w1c = wdata[NSRC-1:0];
    ack_clr = take_ack ? id_onehot : '0;
    pend_d  = (pend_q & ~(w1c | ack_clr)) | edge_det;
  end

  // Mask and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  // Zero-extended combinational read-back.
  always_comb begin
    rdata = '0;
    if (mask_hit) begin
      rdata[NSRC-1:0] = mask_q;
    end else if (pend_hit) begin
      rdata[NSRC-1:0] = pend_q;
    end
  end

  assign eligible = ie ? (pend_q & mask_q) : '0;

  // One-hot of the latched ID, so per-source lookups avoid a variable index.
  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      id_onehot[i] = (irq_id_q == 3'(i));
    end
  end

  // The request stays alive only while its source is still pending, unmasked and globally enabled.
  assign cur_live = |(eligible & id_onehot);

  irq_arb #(
    .NSRC(NSRC)
  ) u_arb (
    .eligible_i(eligible),
    .last_i    (last),
    .valid_o   (arb_valid),
    .id_o      (arb_id)
  );

`ifdef IRQ_ROTATE_PRI_EN
  logic [2:0] last_q;

  // Last-granted pointer advances when the CPU takes an interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (take_ack) begin
      last_q <= irq_id_q;
    end
  end

  assign last = last_q;
`else
  assign last = '0;
`endif

  // Request FSM next-state and ID latch.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    take_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          irq_id_d = arb_id;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (irq_ack) begin
          take_ack = 1'b1;
          state_d  = StService;
        end else if (!cur_live) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (irq_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latched ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq_req = (state_q == StReq);
  assign irq_id  = irq_id_q;

endmodule
